pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 6 +
 rtl/pipe_adder_slice.sv | 41 ++++
 rtl/pipe_adder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared defaults for the pipelined adder: operand width and pipeline depth.
// Nothing else is shared between the adder files.
package pipe_adder_pkg;
   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;
endpackage

// File: rtl/pipe_adder_slice.sv
// One registered slice of the pipelined adder: adds an SW-bit slice plus carry-in
// and registers the sum slice, the carry-out and the stage valid bit.
module adder_slice
   import pipe_adder_pkg::*;
#(
   parameter int SW = DEFAULT_WIDTH / DEFAULT_STAGES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          src_valid,
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic          valid,
   output logic [SW-1:0] sum,
   output logic          cout
);
   logic [SW:0]   total_next;
   logic          valid_reg;
   logic [SW-1:0] sum_reg;
   logic          cout_reg;

   assign total_next = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else if (en) begin
         valid_reg <= src_valid;
         sum_reg   <= total_next[SW-1:0];
         cout_reg  <= total_next[SW];
      end
   end

   assign valid = valid_reg;
   assign sum   = sum_reg;
   assign cout  = cout_reg;
endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: stage k adds slice k, with skew registers
// carrying the not-yet-added operand slices forward and completed sum slices along.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data1_in,
   input  logic [WIDTH-1:0] data2_in,
   input  logic             car_in,
   input  logic             sub_in,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             car_out,
   output logic             ovf_o,
   output logic             zero_o
);
   localparam int SW = WIDTH / STAGES;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] final_sum;

   logic [WIDTH-1:0] a_src      [STAGES];
   logic [WIDTH-1:0] b_src      [STAGES];
   logic             valid_src  [STAGES];
   logic             carry_src  [STAGES];
   logic             a_sign_src [STAGES];
   logic             b_sign_src [STAGES];

   logic [WIDTH-1:0] a_skew_reg   [STAGES];
   logic [WIDTH-1:0] b_skew_reg   [STAGES];
   logic [WIDTH-1:0] sum_skew_reg [STAGES];
   logic             a_sign_reg   [STAGES];
   logic             b_sign_reg   [STAGES];

   logic             valid_stage [STAGES];
   logic             carry_stage [STAGES];
   logic [SW-1:0]    slice_sum   [STAGES];
   logic [WIDTH-1:0] stage_sum   [STAGES];

   // Whole-pipe stall: every stage moves together or nothing moves.
   assign adv     = !valid_o || ready_i;
   assign ready_o = adv;
   assign b_eff   = sub_in ? ~data2_in : data2_in;

   always_comb begin
      a_src[0]      = data1_in;
      b_src[0]      = b_eff;
      valid_src[0]  = valid_i;
      carry_src[0]  = car_in;
      a_sign_src[0] = data1_in[WIDTH-1];
      b_sign_src[0] = b_eff[WIDTH-1];
      for (int k = 1; k < STAGES; k++) begin
         a_src[k]      = a_skew_reg[k-1];
         b_src[k]      = b_skew_reg[k-1];
         valid_src[k]  = valid_stage[k-1];
         carry_src[k]  = carry_stage[k-1];
         a_sign_src[k] = a_sign_reg[k-1];
         b_sign_src[k] = b_sign_reg[k-1];
      end
   end

   // Sum so far at each stage: lower slices from the skew register, slice k fresh.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         stage_sum[k]              = sum_skew_reg[k];
         stage_sum[k][k*SW +: SW]  = slice_sum[k];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < STAGES; k++) begin
            a_skew_reg[k]   <= '0;
            b_skew_reg[k]   <= '0;
            sum_skew_reg[k] <= '0;
            a_sign_reg[k]   <= 1'b0;
            b_sign_reg[k]   <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            a_skew_reg[k] <= a_src[k];
            b_skew_reg[k] <= b_src[k];
            a_sign_reg[k] <= a_sign_src[k];
            b_sign_reg[k] <= b_sign_src[k];
         end
         for (int k = 1; k < STAGES; k++) begin
            sum_skew_reg[k] <= stage_sum[k-1];
         end
      end
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      adder_slice #(
         .SW (SW)
      ) u_slice (
         .clk       (clk_i),
         .rst_n     (rst_i),
         .en        (adv),
         .src_valid (valid_src[gi]),
         .a         (a_src[gi][gi*SW +: SW]),
         .b         (b_src[gi][gi*SW +: SW]),
         .cin       (carry_src[gi]),
         .valid     (valid_stage[gi]),
         .sum       (slice_sum[gi]),
         .cout      (carry_stage[gi])
      );
   end

   // Outputs are forced to zero whenever no result is presented.
   assign valid_o   = valid_stage[STAGES-1];
   assign final_sum = stage_sum[STAGES-1];
   assign data_o    = valid_o ? final_sum : '0;
   assign car_out   = valid_o && carry_stage[STAGES-1];
   assign ovf_o     = valid_o && (a_sign_reg[STAGES-1] == b_sign_reg[STAGES-1])
                              && (final_sum[WIDTH-1] != a_sign_reg[STAGES-1]);
   assign zero_o    = valid_o && (final_sum == '0);
endmodule
